mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage between the ALU stage and writeback: consumes the EX result, performs RV32I load/store to data RAM.
//  Non-memory ops pass through to writeback after one registered cycle.
//  Loads are aligned and sign/zero-extended. Stores drive byte enables. Misaligned or illegal accesses are flagged, not issued.
// PARAMETERS
//  XLEN        32  datapath width
//  RAM_ADDR_W  32  data RAM byte-address width; ram_addr[1:0] always 0
// PORTS
//  clk           in   1        sole clock, rising edge
//  reset         in   1        synchronous, active-high
//  ex_valid      in   1        EX result valid this cycle
//  ex_ready      out  1        stage can accept (state==IDLE)
//  ex_is_load    in   1        load op
//  ex_is_store   in   1        store op
//  ex_funct3     in   3        RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_alu_result in   XLEN     effective address (mem op) or result (other)
//  ex_store_data in   XLEN     rs2 value for stores
//  ex_rd_addr    in   5        destination register
//  ram_req       out  1        access request; held until ram_ready
//  ram_we        out  1        1=write
//  ram_addr      out  RAM_ADDR_W  word-aligned address
//  ram_wdata     out  XLEN     lane-replicated store data
//  ram_be        out  4        byte enables (write only; 4'hF for reads)
//  ram_ready     in   1        request accepted this cycle
//  ram_rvalid    in   1        read data valid (≥1 cycle after ram_ready)
//  ram_rdata     in   XLEN     read word
//  wb_valid      out  1        one-cycle pulse to writeback
//  wb_wr_en      out  1        register write requested (0 for stores, errors, rd==0)
//  wb_rd_addr    out  5        destination register
//  wb_data       out  XLEN     result / extended load data
//  mem_err       out  1        one-cycle pulse: misaligned or illegal funct3
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0 except ex_ready=1; in-flight access discarded, no wb_valid emitted.
//  Accept on ex_valid&&ex_ready; latch op fields.
//  FSM: IDLE -> RESP (non-mem / error) | REQ (mem).
//       REQ holds ram_req until ram_ready; then store->RESP, load->WAIT_RD.
//       WAIT_RD -> RESP on ram_rvalid.
//       RESP -> IDLE, wb_valid=1.
//  Latency accept->wb_valid: non-mem 1; store 1+ready wait; load 2+ready wait+rvalid wait.
//  ram_rvalid outside WAIT_RD is ignored. No new accept while in REQ/WAIT_RD/RESP (ex_ready=0).
//  Misaligned: H with addr[0]=1, W with addr[1:0]!=0. Illegal: funct3 011/110/111, or 100/101 on store.
//  On misaligned/illegal: no ram_req; RESP with wb_wr_en=0; mem_err=1 same cycle as wb_valid.
//  Store: SB be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{d[15:0]}}; SW be=F.
//  Load: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W as-is.
//  wb_wr_en forced 0 when rd==0. Outputs registered; wb_* change only in RESP.
//  ex_is_load&&ex_is_store both set: treated as illegal.
// CONFIGURATION
//  MEM_STAGE_FWD_EN defined: adds outputs fwd_valid(1), fwd_rd_addr(5), fwd_data(XLEN).
//    These mirror wb_valid&&wb_wr_en, wb_rd_addr, wb_data combinationally, for RAW forwarding into ALU operand muxes.
//  MEM_STAGE_FWD_EN undefined: ports absent; hazard logic relies on writeback only.
// STRUCTURE
//  Pipeline stage register package gains EX_MEM and MEM_WB struct typedefs, mem_state_e enum {IDLE,REQ,WAIT_RD,RESP},
//  and funct3 localparams F3_B/H/W/BU/HU.
//  Sub-module mem_lane_align (combinational):
//    store lane placement + byte enables; load lane extraction + extension; misalign/illegal detect.
// TESTING
//  Non-mem: alu_result=0x1234, rd=5 -> wb_valid 1 cycle later, wb_data=0x1234, wb_wr_en=1, no ram_req.
//  LB addr 0x103, rdata 0x80FF_FF7F -> ram_addr 0x100, wb_data 0xFFFF_FF80.
//    LBU same -> 0x0000_0080.
//  SH addr 0x202, data 0xABCD_1234 -> ram_be 1100, ram_wdata 0x1234_1234, ram_we=1, wb_wr_en=0.
//  LW addr 0x101 -> no ram_req, mem_err=1 with wb_valid, wb_wr_en=0.
//    LW to rd=0 -> wb_wr_en=0.
//  Backpressure: ram_ready low 3 cycles -> ram_req/addr stable, ex_ready=0 throughout.
//    Stray rvalid in REQ ignored.
//  Reset asserted in WAIT_RD -> next cycle IDLE, ram_req=0, no wb_valid; subsequent op completes normally.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: EX->MEM and MEM->WB stage records, FSM states, RV32I load/store size codes.
package mem_access_stage_pkg;

   localparam int MEM_XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT_RD = 2'd2,
      RESP    = 2'd3
   } mem_state_e;

   typedef struct packed {
      logic       is_load;
      logic [2:0] funct3;
      logic [1:0] addr_lo;
      logic [4:0] rd_addr;
   } ex_mem_t;

   typedef struct packed {
      logic                valid;
      logic                wr_en;
      logic [4:0]          rd_addr;
      logic [MEM_XLEN-1:0] data;
      logic                err;
   } mem_wb_t;

   // x0 is hardwired to zero, so it never takes a write.
   function automatic logic rd_writes(input logic [4:0] rd);
      return (rd != 5'd0);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational RV32I lane logic: store byte placement/enables, access legality, load lane extraction/extension.
module mem_lane_align
   import mem_access_stage_pkg::*;
(
   input  logic        req_is_load,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_store_data,
   output logic [3:0]  req_be,
   output logic [31:0] req_wdata,
   output logic        req_err,
   input  logic [2:0]  rsp_funct3,
   input  logic [1:0]  rsp_addr_lo,
   input  logic [31:0] rsp_rdata,
   output logic [31:0] rsp_load_data
);

   logic        illegal_s;
   logic        misalign_s;
   logic [31:0] lane_s;

   // Store data is replicated across lanes so the RAM only needs the byte enables.
   always_comb begin
      req_be    = 4'hF;
      req_wdata = req_store_data;
      case (req_funct3)
         F3_B: begin
            req_be    = 4'b0001 << req_addr_lo;
            req_wdata = {4{req_store_data[7:0]}};
         end
         F3_H: begin
            req_be    = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{req_store_data[15:0]}};
         end
         default: begin
            req_be    = 4'hF;
            req_wdata = req_store_data;
         end
      endcase
   end

   // Unsigned sizes exist only for loads; a load+store op is never legal.
   always_comb begin
      illegal_s  = 1'b0;
      misalign_s = 1'b0;
      case (req_funct3)
         F3_B:  misalign_s = 1'b0;
         F3_H:  misalign_s = req_addr_lo[0];
         F3_W:  misalign_s = (req_addr_lo != 2'b00);
         F3_BU: illegal_s  = req_is_store;
         F3_HU: begin
            illegal_s  = req_is_store;
            misalign_s = req_addr_lo[0];
         end
         default: illegal_s = 1'b1;
      endcase
      req_err = (req_is_load || req_is_store) &&
                (illegal_s || misalign_s || (req_is_load && req_is_store));
   end

   assign lane_s = rsp_rdata >> {rsp_addr_lo, 3'b000};

   // Word loads are always aligned, so the shifted lane equals the raw word.
   always_comb begin
      case (rsp_funct3)
         F3_B:    rsp_load_data = {{24{lane_s[7]}}, lane_s[7:0]};
         F3_BU:   rsp_load_data = {24'd0, lane_s[7:0]};
         F3_H:    rsp_load_data = {{16{lane_s[15]}}, lane_s[15:0]};
         F3_HU:   rsp_load_data = {16'd0, lane_s[15:0]};
         default: rsp_load_data = lane_s;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: RV32I load/store to data RAM, pass-through of non-memory results to writeback.
// Optional macro MEM_STAGE_FWD_EN adds combinational forwarding outputs mirroring the writeback port.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int RAM_ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic                  ex_is_load,
   input  logic                  ex_is_store,
   input  logic [2:0]            ex_funct3,
   input  logic [XLEN-1:0]       ex_alu_result,
   input  logic [XLEN-1:0]       ex_store_data,
   input  logic [4:0]            ex_rd_addr,
   output logic                  ram_req,
   output logic                  ram_we,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [XLEN-1:0]       ram_wdata,
   output logic [3:0]            ram_be,
   input  logic                  ram_ready,
   input  logic                  ram_rvalid,
   input  logic [XLEN-1:0]       ram_rdata,
   output logic                  wb_valid,
   output logic                  wb_wr_en,
   output logic [4:0]            wb_rd_addr,
   output logic [XLEN-1:0]       wb_data,
   output logic                  mem_err
`ifdef MEM_STAGE_FWD_EN
   ,
   output logic                  fwd_valid,
   output logic [4:0]            fwd_rd_addr,
   output logic [XLEN-1:0]       fwd_data
`endif
);

   mem_state_e            state_r;
   mem_state_e            state_n;
   ex_mem_t               ex_mem_r;
   mem_wb_t               wb_r;
   logic                  ex_ready_r;
   logic                  ram_req_r;
   logic                  ram_we_r;
   logic [RAM_ADDR_W-1:0] ram_addr_r;
   logic [XLEN-1:0]       ram_wdata_r;
   logic [3:0]            ram_be_r;

   logic                  accept_s;
   logic                  mem_op_s;
   logic                  err_s;
   logic [3:0]            be_s;
   logic [XLEN-1:0]       wdata_s;
   logic [XLEN-1:0]       load_data_s;

   assign accept_s = ex_valid && ex_ready_r;
   assign mem_op_s = ex_is_load || ex_is_store;

   // Request side sees the incoming op; response side sees the latched op.
   mem_lane_align u_align (
      .req_is_load    (ex_is_load),
      .req_is_store   (ex_is_store),
      .req_funct3     (ex_funct3),
      .req_addr_lo    (ex_alu_result[1:0]),
      .req_store_data (ex_store_data),
      .req_be         (be_s),
      .req_wdata      (wdata_s),
      .req_err        (err_s),
      .rsp_funct3     (ex_mem_r.funct3),
      .rsp_addr_lo    (ex_mem_r.addr_lo),
      .rsp_rdata      (ram_rdata),
      .rsp_load_data  (load_data_s)
   );

   // Next-state logic.
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_n = (mem_op_s && !err_s) ? REQ : RESP;
            end else begin
               state_n = IDLE;
            end
         end
         REQ: begin
            if (ram_ready) begin
               state_n = ex_mem_r.is_load ? WAIT_RD : RESP;
            end else begin
               state_n = REQ;
            end
         end
         WAIT_RD: begin
            if (ram_rvalid) begin
               state_n = RESP;
            end else begin
               state_n = WAIT_RD;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Registered RAM and writeback outputs; writeback fields load on entry to RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_ready_r  <= 1'b1;
         ex_mem_r    <= '0;
         wb_r        <= '0;
         ram_req_r   <= 1'b0;
         ram_we_r    <= 1'b0;
         ram_addr_r  <= '0;
         ram_wdata_r <= '0;
         ram_be_r    <= 4'h0;
      end else begin
         ex_ready_r <= (state_n == IDLE);
         wb_r.valid <= 1'b0;
         wb_r.err   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  ex_mem_r.is_load <= ex_is_load;
                  ex_mem_r.funct3  <= ex_funct3;
                  ex_mem_r.addr_lo <= ex_alu_result[1:0];
                  ex_mem_r.rd_addr <= ex_rd_addr;
                  if (mem_op_s && !err_s) begin
                     ram_req_r   <= 1'b1;
                     ram_we_r    <= ex_is_store;
                     ram_addr_r  <= {ex_alu_result[RAM_ADDR_W-1:2], 2'b00};
                     ram_wdata_r <= ex_is_store ? wdata_s : '0;
                     ram_be_r    <= ex_is_store ? be_s : 4'hF;
                  end else begin
                     wb_r.valid   <= 1'b1;
                     wb_r.wr_en   <= !err_s && rd_writes(ex_rd_addr);
                     wb_r.rd_addr <= ex_rd_addr;
                     wb_r.data    <= ex_alu_result;
                     wb_r.err     <= err_s;
                  end
               end
            end
            REQ: begin
               if (ram_ready) begin
                  ram_req_r <= 1'b0;
                  if (!ex_mem_r.is_load) begin
                     wb_r.valid   <= 1'b1;
                     wb_r.wr_en   <= 1'b0;
                     wb_r.rd_addr <= ex_mem_r.rd_addr;
                     wb_r.data    <= '0;
                  end
               end
            end
            WAIT_RD: begin
               if (ram_rvalid) begin
                  wb_r.valid   <= 1'b1;
                  wb_r.wr_en   <= rd_writes(ex_mem_r.rd_addr);
                  wb_r.rd_addr <= ex_mem_r.rd_addr;
                  wb_r.data    <= load_data_s;
               end
            end
            default: ;
         endcase
      end
   end

   assign ex_ready   = ex_ready_r;
   assign ram_req    = ram_req_r;
   assign ram_we     = ram_we_r;
   assign ram_addr   = ram_addr_r;
   assign ram_wdata  = ram_wdata_r;
   assign ram_be     = ram_be_r;
   assign wb_valid   = wb_r.valid;
   assign wb_wr_en   = wb_r.wr_en;
   assign wb_rd_addr = wb_r.rd_addr;
   assign wb_data    = wb_r.data;
   assign mem_err    = wb_r.err;

`ifdef MEM_STAGE_FWD_EN
   assign fwd_valid   = wb_r.valid && wb_r.wr_en;
   assign fwd_rd_addr = wb_r.rd_addr;
   assign fwd_data    = wb_r.data;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (default build, forwarding ports absent).
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [4:0]  ex_rd_addr;
   logic        ram_req, ram_we;
   logic [31:0] ram_addr, ram_wdata;
   logic [3:0]  ram_be;
   logic        ram_ready, ram_rvalid;
   logic [31:0] ram_rdata;
   logic        wb_valid, wb_wr_en;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic        mem_err;

   int n_cmp = 0;
   int n_mis = 0;

   // load table, all against RAM word 0x80FF_FF7F
   logic [2:0]  ld_f3   [8] = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
   logic [31:0] ld_addr [8] = '{32'h103, 32'h103, 32'h101, 32'h100, 32'h102, 32'h102, 32'h100, 32'h100};
   logic [31:0] ld_exp  [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFFF, 32'h0000_007F,
                                32'hFFFF_80FF, 32'h0000_80FF, 32'hFFFF_FF7F, 32'h80FF_FF7F};

   logic [2:0]  st_f3    [5] = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b000};
   logic [31:0] st_addr  [5] = '{32'h201, 32'h202, 32'h200, 32'h300, 32'h303};
   logic [31:0] st_data  [5] = '{32'h0000_00AB, 32'hABCD_1234, 32'hABCD_1234, 32'hDEAD_BEEF, 32'h0000_0011};
   logic [3:0]  st_be    [5] = '{4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1000};
   logic [31:0] st_wdata [5] = '{32'hABAB_ABAB, 32'h1234_1234, 32'h1234_1234, 32'hDEAD_BEEF, 32'h1111_1111};
   logic [31:0] st_waddr [5] = '{32'h200, 32'h200, 32'h200, 32'h300, 32'h300};

   // error table: load, store, funct3, address
   logic        er_ld   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic        er_st   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [2:0]  er_f3   [8] = '{3'b010, 3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b010, 3'b110};
   logic [31:0] er_addr [8] = '{32'h101, 32'h103, 32'h203, 32'h202, 32'h100, 32'h100, 32'h100, 32'h000};

   mem_access_stage dut (
      .clk           (clk),
      .reset         (reset),
      .ex_valid      (ex_valid),
      .ex_ready      (ex_ready),
      .ex_is_load    (ex_is_load),
      .ex_is_store   (ex_is_store),
      .ex_funct3     (ex_funct3),
      .ex_alu_result (ex_alu_result),
      .ex_store_data (ex_store_data),
      .ex_rd_addr    (ex_rd_addr),
      .ram_req       (ram_req),
      .ram_we        (ram_we),
      .ram_addr      (ram_addr),
      .ram_wdata     (ram_wdata),
      .ram_be        (ram_be),
      .ram_ready     (ram_ready),
      .ram_rvalid    (ram_rvalid),
      .ram_rdata     (ram_rdata),
      .wb_valid      (wb_valid),
      .wb_wr_en      (wb_wr_en),
      .wb_rd_addr    (wb_rd_addr),
      .wb_data       (wb_data),
      .mem_err       (mem_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one op for a single edge; caller guarantees the stage is idle.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
      ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
      ex_alu_result = alu; ex_store_data = sd; ex_rd_addr = rd;
      step();
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      n_cmp++; if (ex_ready !== 1'b1) begin n_mis++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
      n_cmp++; if (ram_req !== 1'b0) begin n_mis++; $display("FAIL reset_ram_req: got %b want 0", ram_req); end
      n_cmp++; if (wb_valid !== 1'b0) begin n_mis++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
      n_cmp++; if (mem_err !== 1'b0) begin n_mis++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
      n_cmp++; if (wb_data !== 32'h0) begin n_mis++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
      n_cmp++; if (ram_be !== 4'h0) begin n_mis++; $display("FAIL reset_ram_be: got %h want 0", ram_be); end
      reset = 1'b0;
      step();
      n_cmp++; if (ex_ready !== 1'b1) begin n_mis++; $display("FAIL post_reset_ex_ready: got %b want 1", ex_ready); end
   endtask

   task automatic test_nonmem();
      issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5);
      n_cmp++; if (wb_valid !== 1'b1) begin n_mis++; $display("FAIL nonmem_wb_valid: got %b want 1", wb_valid); end
      n_cmp++; if (wb_data !== 32'h1234) begin n_mis++; $display("FAIL nonmem_wb_data: got %h want 00001234", wb_data); end
      n_cmp++; if (wb_wr_en !== 1'b1) begin n_mis++; $display("FAIL nonmem_wb_wr_en: got %b want 1", wb_wr_en); end
      n_cmp++; if (wb_rd_addr !== 5'd5) begin n_mis++; $display("FAIL nonmem_rd: got %0d want 5", wb_rd_addr); end
      n_cmp++; if (ram_req !== 1'b0) begin n_mis++; $display("FAIL nonmem_ram_req: got %b want 0", ram_req); end
      n_cmp++; if (mem_err !== 1'b0) begin n_mis++; $display("FAIL nonmem_mem_err: got %b want 0", mem_err); end
      n_cmp++; if (ex_ready !== 1'b0) begin n_mis++; $display("FAIL nonmem_ex_ready_resp: got %b want 0", ex_ready); end
      step();
      n_cmp++; if (wb_valid !== 1'b0) begin n_mis++; $display("FAIL nonmem_wb_pulse: got %b want 0", wb_valid); end
      n_cmp++; if (ex_ready !== 1'b1) begin n_mis++; $display("FAIL nonmem_ex_ready_idle: got %b want 1", ex_ready); end
   endtask

   task automatic test_loads();
      for (int i = 0; i < 8; i++) begin
         ram_ready = 1'b0;
         issue(1'b1, 1'b0, ld_f3[i], ld_addr[i], 32'h0, 5'd7);
         n_cmp++; if (ram_req !== 1'b1) begin n_mis++; $display("FAIL load%0d_ram_req: got %b want 1", i, ram_req); end
         n_cmp++; if (ram_addr !== {ld_addr[i][31:2], 2'b00}) begin n_mis++; $display("FAIL load%0d_ram_addr: got %h want %h", i, ram_addr, {ld_addr[i][31:2], 2'b00}); end
         n_cmp++; if (ram_we !== 1'b0 || ram_be !== 4'hF) begin n_mis++; $display("FAIL load%0d_we_be: got we=%b be=%h want we=0 be=f", i, ram_we, ram_be); end
         ram_ready = 1'b1;
         step();
         ram_ready = 1'b0;
         n_cmp++; if (ram_req !== 1'b0 || wb_valid !== 1'b0) begin n_mis++; $display("FAIL load%0d_wait_rd: got req=%b wb=%b want 0 0", i, ram_req, wb_valid); end
         ram_rvalid = 1'b1; ram_rdata = 32'h80FF_FF7F;
         step();
         ram_rvalid = 1'b0;
         n_cmp++; if (wb_valid !== 1'b1) begin n_mis++; $display("FAIL load%0d_wb_valid: got %b want 1", i, wb_valid); end
         n_cmp++; if (wb_data !== ld_exp[i]) begin n_mis++; $display("FAIL load%0d_wb_data: got %h want %h", i, wb_data, ld_exp[i]); end
         n_cmp++; if (wb_wr_en !== 1'b1 || wb_rd_addr !== 5'd7) begin n_mis++; $display("FAIL load%0d_wb_wr: got en=%b rd=%0d want 1 7", i, wb_wr_en, wb_rd_addr); end
         step();
      end
   endtask

   task automatic test_stores();
      for (int i = 0; i < 5; i++) begin
         ram_ready = 1'b0;
         issue(1'b0, 1'b1, st_f3[i], st_addr[i], st_data[i], 5'd9);
         n_cmp++; if (ram_req !== 1'b1 || ram_we !== 1'b1) begin n_mis++; $display("FAIL store%0d_req_we: got req=%b we=%b want 1 1", i, ram_req, ram_we); end
         n_cmp++; if (ram_be !== st_be[i]) begin n_mis++; $display("FAIL store%0d_be: got %b want %b", i, ram_be, st_be[i]); end
         n_cmp++; if (ram_wdata !== st_wdata[i]) begin n_mis++; $display("FAIL store%0d_wdata: got %h want %h", i, ram_wdata, st_wdata[i]); end
         n_cmp++; if (ram_addr !== st_waddr[i]) begin n_mis++; $display("FAIL store%0d_addr: got %h want %h", i, ram_addr, st_waddr[i]); end
         ram_ready = 1'b1;
         step();
         ram_ready = 1'b0;
         n_cmp++; if (wb_valid !== 1'b1 || wb_wr_en !== 1'b0) begin n_mis++; $display("FAIL store%0d_wb: got valid=%b wr_en=%b want 1 0", i, wb_valid, wb_wr_en); end
         n_cmp++; if (ram_req !== 1'b0 || mem_err !== 1'b0) begin n_mis++; $display("FAIL store%0d_done: got req=%b err=%b want 0 0", i, ram_req, mem_err); end
         step();
      end
   endtask

   task automatic test_errors();
      ram_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         issue(er_ld[i], er_st[i], er_f3[i], er_addr[i], 32'h5555_5555, 5'd4);
         n_cmp++; if (ram_req !== 1'b0) begin n_mis++; $display("FAIL err%0d_ram_req: got %b want 0", i, ram_req); end
         n_cmp++; if (wb_valid !== 1'b1 || mem_err !== 1'b1) begin n_mis++; $display("FAIL err%0d_pulse: got valid=%b err=%b want 1 1", i, wb_valid, mem_err); end
         n_cmp++; if (wb_wr_en !== 1'b0) begin n_mis++; $display("FAIL err%0d_wr_en: got %b want 0", i, wb_wr_en); end
         step();
         n_cmp++; if (mem_err !== 1'b0 || wb_valid !== 1'b0 || ram_req !== 1'b0) begin n_mis++; $display("FAIL err%0d_after: got err=%b valid=%b req=%b want 0 0 0", i, mem_err, wb_valid, ram_req); end
      end
      ram_ready = 1'b0;
   endtask

   task automatic test_rd_zero();
      ram_ready = 1'b1;
      issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd0);
      step();
      ram_ready = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'h0000_0055;
      step();
      ram_rvalid = 1'b0;
      n_cmp++; if (wb_valid !== 1'b1 || wb_wr_en !== 1'b0) begin n_mis++; $display("FAIL rd0_load: got valid=%b wr_en=%b want 1 0", wb_valid, wb_wr_en); end
      n_cmp++; if (wb_data !== 32'h55) begin n_mis++; $display("FAIL rd0_load_data: got %h want 00000055", wb_data); end
      step();
      issue(1'b0, 1'b0, 3'b000, 32'h99, 32'h0, 5'd0);
      n_cmp++; if (wb_valid !== 1'b1 || wb_wr_en !== 1'b0) begin n_mis++; $display("FAIL rd0_nonmem: got valid=%b wr_en=%b want 1 0", wb_valid, wb_wr_en); end
      step();
   endtask

   task automatic test_backpressure();
      ram_ready = 1'b0;
      issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd12);
      // competing op held on the input while the load is in flight
      ex_valid = 1'b1; ex_funct3 = 3'b000; ex_alu_result = 32'hBAD; ex_rd_addr = 5'd3;
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if (ram_req !== 1'b1 || ram_addr !== 32'h400) begin n_mis++; $display("FAIL bp%0d_req_addr: got req=%b addr=%h want 1 00000400", c, ram_req, ram_addr); end
         n_cmp++; if (ex_ready !== 1'b0 || wb_valid !== 1'b0) begin n_mis++; $display("FAIL bp%0d_ready_wb: got ready=%b wb=%b want 0 0", c, ex_ready, wb_valid); end
         ram_rvalid = (c == 1);
         ram_rdata = 32'hDEAD_0000;
         step();
      end
      ram_rvalid = 1'b0;
      n_cmp++; if (ram_req !== 1'b1 || wb_valid !== 1'b0) begin n_mis++; $display("FAIL bp_stray_rvalid: got req=%b wb=%b want 1 0", ram_req, wb_valid); end
      ram_ready = 1'b1;
      step();
      ram_ready = 1'b0;
      n_cmp++; if (ram_req !== 1'b0 || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin n_mis++; $display("FAIL bp_wait_rd: got req=%b ready=%b wb=%b want 0 0 0", ram_req, ex_ready, wb_valid); end
      ram_rvalid = 1'b1; ram_rdata = 32'h1122_3344;
      step();
      ram_rvalid = 1'b0; ex_valid = 1'b0;
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h1122_3344 || wb_rd_addr !== 5'd12) begin n_mis++; $display("FAIL bp_wb: got valid=%b data=%h rd=%0d want 1 11223344 12", wb_valid, wb_data, wb_rd_addr); end
      step();
      step();
      n_cmp++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin n_mis++; $display("FAIL bp_no_extra_op: got wb=%b ready=%b want 0 1", wb_valid, ex_ready); end
   endtask

   task automatic test_reset_midflight();
      ram_ready = 1'b1;
      issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd6);
      step();
      ram_ready = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (ram_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin n_mis++; $display("FAIL rst_mid_state: got req=%b ready=%b wb=%b want 0 1 0", ram_req, ex_ready, wb_valid); end
      ram_rvalid = 1'b1; ram_rdata = 32'hCAFE_F00D;
      step();
      ram_rvalid = 1'b0;
      n_cmp++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin n_mis++; $display("FAIL rst_mid_stale_rvalid: got wb=%b ready=%b want 0 1", wb_valid, ex_ready); end
      issue(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd2);
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h77 || wb_rd_addr !== 5'd2) begin n_mis++; $display("FAIL rst_mid_next_op: got valid=%b data=%h rd=%0d want 1 00000077 2", wb_valid, wb_data, wb_rd_addr); end
      step();
   endtask

   initial begin
      reset = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
      ex_funct3 = 3'b000; ex_alu_result = 32'h0; ex_store_data = 32'h0; ex_rd_addr = 5'd0;
      ram_ready = 1'b0; ram_rvalid = 1'b0; ram_rdata = 32'h0;
      #1;
      test_reset();
      test_nonmem();
      test_loads();
      test_stores();
      test_errors();
      test_rd_zero();
      test_backpressure();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "time limit");
   end

endmodule
